// File: rtl/richie_pkg.sv
// Shared datapath constants for the RichieJr CPU.
package richie_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit behavioural adder with carry-in and carry-out.
module alu_adder
  import richie_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/alu.sv
// Add/subtract unit: combinational result, registered carry and zero flags.
module alu
  import richie_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             raw_carry;
  logic             raw_zero;

  // Two's complement subtract: invert B and feed the op bit in as carry-in.
  assign is_sub = (sub == ALU_SUB);
  assign b_eff  = B ^ {WIDTH{is_sub}};

  alu_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a    (A),
    .b    (b_eff),
    .cin  (is_sub),
    .sum  (result),
    .cout (raw_carry)
  );

  assign raw_zero = (result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      carryFlag <= 1'b0;
      zeroFlag  <= 1'b0;
    end else begin
      carryFlag <= raw_carry;
      zeroFlag  <= raw_zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu add/subtract unit.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       sub;
  logic [7:0] result;
  logic       carryFlag;
  logic       zeroFlag;

  int unsigned n_cmp;
  int unsigned n_bad;

  alu #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .result    (result),
    .carryFlag (carryFlag),
    .zeroFlag  (zeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; A = 8'hFF; B = 8'h01; sub = 1'b0;
    #1;
    n_cmp++;
    if (result !== 8'h00) begin
      n_bad++; $display("FAIL reset_result: got %h expected %h", result, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (carryFlag !== 1'b0) begin
        n_bad++; $display("FAIL reset_carry[%0d]: got %b expected 0", i, carryFlag);
      end
      n_cmp++;
      if (zeroFlag !== 1'b0) begin
        n_bad++; $display("FAIL reset_zero[%0d]: got %b expected 0", i, zeroFlag);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (carryFlag !== 1'b1) begin
      n_bad++; $display("FAIL release_carry: got %b expected 1", carryFlag);
    end
    n_cmp++;
    if (zeroFlag !== 1'b1) begin
      n_bad++; $display("FAIL release_zero: got %b expected 1", zeroFlag);
    end
  endtask

  task automatic test_add();
    @(negedge clk);
    A = 8'h69; B = 8'h02; sub = 1'b0;
    #1;
    n_cmp++;
    if (result !== 8'h6B) begin
      n_bad++; $display("FAIL add_result: got %h expected %h", result, 8'h6B);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b00) begin
      n_bad++; $display("FAIL add_flags: got c=%b z=%b expected c=0 z=0", carryFlag, zeroFlag);
    end
  endtask

  task automatic test_sub_no_borrow();
    @(negedge clk);
    A = 8'h69; B = 8'h02; sub = 1'b1;
    #1;
    n_cmp++;
    if (result !== 8'h67) begin
      n_bad++; $display("FAIL sub_nb_result: got %h expected %h", result, 8'h67);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b10) begin
      n_bad++; $display("FAIL sub_nb_flags: got c=%b z=%b expected c=1 z=0", carryFlag, zeroFlag);
    end
  endtask

  task automatic test_sub_borrow();
    @(negedge clk);
    A = 8'h02; B = 8'h69; sub = 1'b1;
    #1;
    n_cmp++;
    if (result !== 8'h99) begin
      n_bad++; $display("FAIL sub_b_result: got %h expected %h", result, 8'h99);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b00) begin
      n_bad++; $display("FAIL sub_b_flags: got c=%b z=%b expected c=0 z=0", carryFlag, zeroFlag);
    end
  endtask

  task automatic test_add_wrap();
    @(negedge clk);
    A = 8'hFF; B = 8'h01; sub = 1'b0;
    #1;
    n_cmp++;
    if (result !== 8'h00) begin
      n_bad++; $display("FAIL wrap_result: got %h expected %h", result, 8'h00);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b11) begin
      n_bad++; $display("FAIL wrap_flags: got c=%b z=%b expected c=1 z=1", carryFlag, zeroFlag);
    end
  endtask

  task automatic test_equal_hold();
    @(negedge clk);
    A = 8'h55; B = 8'h55; sub = 1'b1;
    #1;
    n_cmp++;
    if (result !== 8'h00) begin
      n_bad++; $display("FAIL eq_result: got %h expected %h", result, 8'h00);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b11) begin
      n_bad++; $display("FAIL eq_flags: got c=%b z=%b expected c=1 z=1", carryFlag, zeroFlag);
    end
    @(negedge clk);
    A = 8'h10;
    #1;
    n_cmp++;
    if (result !== 8'hBB) begin
      n_bad++; $display("FAIL hold_result: got %h expected %h", result, 8'hBB);
    end
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b11) begin
      n_bad++; $display("FAIL hold_flags: got c=%b z=%b expected c=1 z=1", carryFlag, zeroFlag);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b00) begin
      n_bad++; $display("FAIL hold_next_flags: got c=%b z=%b expected c=0 z=0", carryFlag, zeroFlag);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    A = 8'h80; B = 8'h80; sub = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (result !== 8'h00) begin
      n_bad++; $display("FAIL midrst_result: got %h expected %h", result, 8'h00);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b00) begin
      n_bad++; $display("FAIL midrst_flags: got c=%b z=%b expected c=0 z=0", carryFlag, zeroFlag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b11) begin
      n_bad++; $display("FAIL midrst_resume: got c=%b z=%b expected c=1 z=1", carryFlag, zeroFlag);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    A = 8'h0F; B = 8'hF1; sub = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_1: got c=%b z=%b expected c=1 z=1", carryFlag, zeroFlag);
    end
    @(negedge clk);
    A = 8'h00; B = 8'h01; sub = 1'b1;
    #1;
    n_cmp++;
    if (result !== 8'hFF) begin
      n_bad++; $display("FAIL b2b_result: got %h expected %h", result, 8'hFF);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({carryFlag, zeroFlag} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_2: got c=%b z=%b expected c=0 z=0", carryFlag, zeroFlag);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; A = '0; B = '0; sub = 1'b0;
    test_reset();
    test_add();
    test_sub_no_borrow();
    test_sub_borrow();
    test_add_wrap();
    test_equal_hold();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
